pll_sweep_ctrl: RTL and testbench

PLL_SWEEP_CTRL -- requirements
Module: pll_sweep_ctrl

---
 rtl/pll_sweep_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_pll_sweep_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_sweep_ctrl.sv
// PLL frequency-profile sweep controller.
// Buttons step or auto-sweep through PLL profiles; each change runs a
// load/settle/arm/wait reconfig sequence against the PLL reconfig engine,
// and elapsed time since the last reconfig is shown as BCD minutes and
// binary seconds.
module pll_sweep_ctrl #(
  parameter int NUM_PROFILES = 11,
  parameter int INIT_POS     = 7,
  parameter int TICK_DIV     = 50000000,
  parameter int DWELL_SECS   = 60,
  parameter int RCFG_TIMEOUT = 1000,
  parameter int WRAP         = 0
) (
  input  logic                            clock_50_i,
  input  logic                            RESET,
  input  logic                            btn_up,
  input  logic                            btn_down,
  input  logic                            btn_auto,
  input  logic                            test_pass,
  input  logic                            test_fail,
  input  logic                            rcfg_busy,
  output logic                            rcfg_load,
  output logic                            rcfg_start,
  output logic                            rcfg_reset,
  output logic [$clog2(NUM_PROFILES)-1:0] pos,
  output logic                            auto_o,
  output logic                            recfg_o,
  output logic [15:0]                     mins,
  output logic [15:0]                     secs,
  output logic                            sweep_done,
  output logic [2:0]                      fsm_state
);

  localparam int PW    = $clog2(NUM_PROFILES);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMO_W = $clog2(RCFG_TIMEOUT + 1);

  localparam logic [PW-1:0]    LAST_POS = PW'(NUM_PROFILES - 1);
  localparam logic [PW-1:0]    INIT     = PW'(INIT_POS);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(RCFG_TIMEOUT);
  localparam logic [15:0]      DWELL    = 16'(DWELL_SECS);

  // Reconfig handshake: rcfg_load and rcfg_start are single-cycle registered
  // pulses; rcfg_start is only issued when rcfg_busy is low, and the engine
  // is considered finished once rcfg_busy is low in a cycle after the start
  // pulse has dropped. If busy never drops, rcfg_reset pulses once instead.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_ARM    = 3'd3,
    S_WAIT   = 3'd4
  } rcfg_state_t;

  rcfg_state_t      state, state_nxt;
  logic [TMO_W-1:0] tmo, tmo_nxt;
  logic             load_nxt, start_nxt, reset_nxt, cycle_done;
  logic             req, new_req;
  logic             up_q, down_q, auto_btn_q;
  logic             up_edge, down_edge, auto_edge;
  logic [PW-1:0]    pos_nxt;
  logic             auto_nxt, done_nxt, advance, dwell_hit;
  logic [DIV_W-1:0] sec_div;
  logic [5:0]       sec_cnt;
  logic [15:0]      dwell;

  // Increment a 4-digit BCD value, 9999 rolls to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign up_edge   = btn_up & ~up_q;
  assign down_edge = btn_down & ~down_q;
  assign auto_edge = btn_auto & ~auto_btn_q;
  assign recfg_o   = req | (state != S_IDLE);
  assign fsm_state = state;
  assign dwell_hit = (DWELL_SECS > 0) && (dwell == DWELL);
  assign advance   = auto_o & ~recfg_o & ((test_pass & test_fail) | dwell_hit);

  // Button history for rising-edge detection.
  always_ff @(posedge clock_50_i) begin
    if (RESET) begin
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      auto_btn_q <= 1'b0;
    end else begin
      up_q       <= btn_up;
      down_q     <= btn_down;
      auto_btn_q <= btn_auto;
    end
  end

  // Profile selection: auto edge beats up, up beats down, buttons beat advance.
  always_comb begin
    pos_nxt  = pos;
    auto_nxt = auto_o;
    done_nxt = sweep_done;
    new_req  = 1'b0;
    if (auto_edge) begin
      if (!auto_o) begin
        pos_nxt  = '0;
        auto_nxt = 1'b1;
        done_nxt = 1'b0;
      end else begin
        auto_nxt = 1'b0;
      end
      new_req = 1'b1;
    end else if (up_edge) begin
      if (pos != '0) begin
        pos_nxt  = pos - PW'(1);
        auto_nxt = 1'b0;
        new_req  = 1'b1;
      end
    end else if (down_edge) begin
      if (pos != LAST_POS) begin
        pos_nxt  = pos + PW'(1);
        auto_nxt = 1'b0;
        new_req  = 1'b1;
      end
    end else if (advance) begin
      if (pos != LAST_POS) begin
        pos_nxt = pos + PW'(1);
        new_req = 1'b1;
      end else if (WRAP != 0) begin
        pos_nxt = '0;
        new_req = 1'b1;
      end else begin
        done_nxt = 1'b1;
        auto_nxt = 1'b0;
      end
    end
  end

  // Profile registers; reset also queues one reconfig to program INIT_POS.
  // The request is consumed when IDLE accepts it, so a request raised while
  // a reconfig is in flight stays pending and is serviced afterwards.
  always_ff @(posedge clock_50_i) begin
    if (RESET) begin
      pos        <= INIT;
      auto_o     <= 1'b0;
      sweep_done <= 1'b0;
      req        <= 1'b1;
    end else begin
      pos        <= pos_nxt;
      auto_o     <= auto_nxt;
      sweep_done <= done_nxt;
      if (new_req) begin
        req <= 1'b1;
      end else if (state == S_IDLE) begin
        req <= 1'b0;
      end
    end
  end

  // Reconfig FSM state and registered pulse outputs.
  always_ff @(posedge clock_50_i) begin
    if (RESET) begin
      state      <= S_IDLE;
      tmo        <= '0;
      rcfg_load  <= 1'b0;
      rcfg_start <= 1'b0;
      rcfg_reset <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmo        <= tmo_nxt;
      rcfg_load  <= load_nxt;
      rcfg_start <= start_nxt;
      rcfg_reset <= reset_nxt;
    end
  end

  // Reconfig FSM next state; the timeout fires on the step that brings tmo to 1.
  always_comb begin
    state_nxt  = state;
    tmo_nxt    = tmo;
    load_nxt   = 1'b0;
    start_nxt  = 1'b0;
    reset_nxt  = 1'b0;
    cycle_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load_nxt  = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        state_nxt = S_ARM;
      end
      S_ARM: begin
        if (!rcfg_busy) begin
          start_nxt = 1'b1;
          tmo_nxt   = TMO_LOAD;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_nxt = tmo - TMO_W'(1);
        if (!rcfg_busy && !rcfg_start) begin
          state_nxt  = S_IDLE;
          cycle_done = 1'b1;
        end else if (tmo <= TMO_W'(2)) begin
          reset_nxt  = 1'b1;
          state_nxt  = S_IDLE;
          cycle_done = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Elapsed-time counters, held at zero while a reconfig is pending.
  always_ff @(posedge clock_50_i) begin
    if (RESET || recfg_o) begin
      sec_div <= '0;
      sec_cnt <= '0;
      secs    <= '0;
      mins    <= '0;
    end else if (sec_div == DIV_MAX) begin
      sec_div <= '0;
      secs    <= secs + 16'd1;
      if (sec_cnt == 6'd59) begin
        sec_cnt <= '0;
        mins    <= bcd_inc(mins);
      end else begin
        sec_cnt <= sec_cnt + 6'd1;
      end
    end else begin
      sec_div <= sec_div + DIV_W'(1);
    end
  end

  // Seconds spent on the current profile, restarted by each reconfig.
  always_ff @(posedge clock_50_i) begin
    if (RESET || cycle_done) begin
      dwell <= '0;
    end else if (!recfg_o && sec_div == DIV_MAX) begin
      dwell <= dwell + 16'd1;
    end
  end

endmodule

// File: tb/tb_pll_sweep_ctrl.sv
// Directed testbench for pll_sweep_ctrl: reset sequence, timers, button
// stepping, edge priority, reconfig timeout, reset abort and auto sweep.
// A second instance with TICK_DIV=1 covers the BCD minute carry.
module tb_pll_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up, btn_down, btn_auto, test_pass, test_fail, rcfg_busy;
  logic        rcfg_load, rcfg_start, rcfg_reset, auto_o, recfg_o, sweep_done;
  logic [3:0]  pos;
  logic [15:0] mins, secs;
  logic [2:0]  fsm_state;

  logic        m_rst;
  logic        m_load, m_start, m_rreset, m_auto, m_recfg, m_done;
  logic [3:0]  m_pos;
  logic [15:0] m_mins, m_secs;
  logic [2:0]  m_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pll_sweep_ctrl #(
    .TICK_DIV(10), .DWELL_SECS(60), .RCFG_TIMEOUT(8), .WRAP(0)
  ) dut (
    .clock_50_i(clk), .RESET(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_auto(btn_auto),
    .test_pass(test_pass), .test_fail(test_fail), .rcfg_busy(rcfg_busy),
    .rcfg_load(rcfg_load), .rcfg_start(rcfg_start), .rcfg_reset(rcfg_reset),
    .pos(pos), .auto_o(auto_o), .recfg_o(recfg_o),
    .mins(mins), .secs(secs), .sweep_done(sweep_done), .fsm_state(fsm_state)
  );

  pll_sweep_ctrl #(
    .TICK_DIV(1)
  ) dut_m (
    .clock_50_i(clk), .RESET(m_rst),
    .btn_up(1'b0), .btn_down(1'b0), .btn_auto(1'b0),
    .test_pass(1'b0), .test_fail(1'b0), .rcfg_busy(1'b0),
    .rcfg_load(m_load), .rcfg_start(m_start), .rcfg_reset(m_rreset),
    .pos(m_pos), .auto_o(m_auto), .recfg_o(m_recfg),
    .mins(m_mins), .secs(m_secs), .sweep_done(m_done), .fsm_state(m_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs change at the falling edge, outputs sampled there too.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse buttons for one cycle: bit0 up, bit1 down, bit2 auto.
  task automatic press(input logic [2:0] mask);
    btn_up   = mask[0];
    btn_down = mask[1];
    btn_auto = mask[2];
    cyc();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_auto = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (recfg_o !== 1'b0 && n < 40) begin
      cyc();
      n++;
    end
    check(tag, recfg_o, 0);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (rcfg_start !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check(tag, rcfg_start, 1);
  endtask

  initial begin
    int   loads, pulses, n, k;
    logic [3:0] last;
    rst = 1'b0; m_rst = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_auto = 1'b0;
    test_pass = 1'b0; test_fail = 1'b0; rcfg_busy = 1'b0;
    @(negedge clk);

    // Reset and the first reconfig sequence.
    rst = 1'b1;
    cyc();
    check("rst_recfg", recfg_o, 1);
    check("rst_pos", pos, 7);
    check("rst_auto", auto_o, 0);
    check("rst_done", sweep_done, 0);
    check("rst_pulses", {rcfg_load, rcfg_start, rcfg_reset}, 0);
    check("rst_time", {mins, secs}, 0);
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      check($sformatf("load_c%0d", c), rcfg_load, (c == 2) ? 1 : 0);
      check($sformatf("start_c%0d", c), rcfg_start, (c == 4) ? 1 : 0);
    end
    check("recfg_low_c6", recfg_o, 0);
    check("state_idle_c6", fsm_state, 0);

    // Elapsed time with 10 cycles per second.
    repeat (599) cyc();
    check("secs_599", secs, 59);
    check("mins_599", mins, 0);
    cyc();
    check("secs_600", secs, 60);
    check("mins_600", mins, 16'h0001);

    // Up eight times from 7: 6..0, last press ignored.
    for (int i = 0; i < 8; i++) begin
      press(3'b001);
      check($sformatf("up_pos%0d", i), pos, (i < 7) ? 6 - i : 0);
      if (i < 7) begin
        check($sformatf("up_req%0d", i), recfg_o, 1);
        wait_idle($sformatf("up_idle%0d", i));
      end else begin
        pulses = 0;
        repeat (8) begin cyc(); pulses += recfg_o; end
        check("up_at0_noreq", pulses, 0);
        check("up_at0_pos", pos, 0);
      end
    end
    check("time_cleared", {mins, secs} == 32'd0 ? 32'd0 : {mins, secs}, 0);

    // Down to 5, then up+down together.
    for (int i = 0; i < 5; i++) begin
      press(3'b010);
      wait_idle("down_idle");
    end
    check("down_pos5", pos, 5);
    press(3'b011);
    check("both_pos", pos, 4);
    loads = 0;
    repeat (12) begin cyc(); loads += rcfg_load; end
    check("both_loads", loads, 1);
    check("both_idle", recfg_o, 0);

    // Busy stuck after start: timeout reset 7 cycles after start.
    press(3'b001);
    wait_start("tmo_start");
    rcfg_busy = 1'b1;
    k = 0;
    while (rcfg_reset !== 1'b1 && k < 30) begin cyc(); k++; end
    check("tmo_gap", k, 7);
    check("tmo_state", fsm_state, 0);
    cyc();
    check("tmo_one_shot", rcfg_reset, 0);
    rcfg_busy = 1'b0;
    check("tmo_recfg", recfg_o, 0);
    check("tmo_pos", pos, 3);

    // Reset while waiting: no timeout pulse, profile back to INIT_POS.
    press(3'b001);
    wait_start("abort_start");
    rcfg_busy = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    check("abort_rreset", rcfg_reset, 0);
    check("abort_state", fsm_state, 0);
    check("abort_pos", pos, 7);
    check("abort_recfg", recfg_o, 1);
    rst = 1'b0;
    rcfg_busy = 1'b0;
    pulses = 0;
    repeat (8) begin cyc(); pulses += rcfg_reset; end
    check("abort_no_pulse", pulses, 0);
    check("abort_idle", recfg_o, 0);

    // Auto sweep with pass&fail forced: 0..10 then done.
    press(3'b100);
    check("auto_on", auto_o, 1);
    check("auto_pos0", pos, 0);
    check("auto_done0", sweep_done, 0);
    test_pass = 1'b1;
    test_fail = 1'b1;
    for (int p = 1; p <= 10; p++) exp_q.push_back(p);
    last = pos;
    n = 0;
    while (sweep_done !== 1'b1 && n < 400) begin
      cyc();
      n++;
      if (pos !== last) begin
        if (exp_q.size() > 0) check("sweep_pos", pos, exp_q.pop_front());
        else check("sweep_extra", pos, last);
        last = pos;
      end
    end
    check("sweep_done", sweep_done, 1);
    check("sweep_left", exp_q.size(), 0);
    check("sweep_auto_off", auto_o, 0);
    check("sweep_pos_last", pos, 10);
    cyc();
    check("sweep_no_req", recfg_o, 0);
    test_pass = 1'b0;
    test_fail = 1'b0;

    // Auto on then off: pos kept, reconfig requested.
    press(3'b100);
    check("auto2_on", auto_o, 1);
    check("auto2_done_clr", sweep_done, 0);
    wait_idle("auto2_idle");
    press(3'b100);
    check("auto_off", auto_o, 0);
    check("auto_off_pos", pos, 0);
    check("auto_off_req", recfg_o, 1);
    wait_idle("auto_off_idle");

    // BCD carry 0999 -> 1000 with one cycle per second.
    m_rst = 1'b1;
    cyc();
    m_rst = 1'b0;
    n = 0;
    while (m_recfg !== 1'b0 && n < 40) begin cyc(); n++; end
    check("m_idle", m_recfg, 0);
    repeat (59940) cyc();
    check("m_mins_999", m_mins, 16'h0999);
    check("m_secs_999", m_secs, 59940);
    repeat (60) cyc();
    check("m_mins_1000", m_mins, 16'h1000);
    check("m_secs_1000", m_secs, 60000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
